// File: rtl/cover_sched_pkg.sv
// Shared types and helpers for the toggle-coverage report scheduler.
package cover_sched_pkg;

    // Flush sequencing states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Global cover index as seen by the reporting back end
    typedef logic [63:0] cover_index_t;

    // Bits needed to encode values 0..n-1, never less than one bit
    function automatic int clog2_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cover_toggle_report_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import cover_sched_pkg::*;
#(
    parameter int N     = 20,
    parameter int PTR_W = 5
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_gnt_valid,
    output logic [PTR_W-1:0] o_gnt_idx
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    int             w_sel;

    // Lower copy keeps only bits >= ptr; upper copy supplies the wrapped bits
    always_comb begin
        // NOTE: every output of a combinational block is assigned a default first so no latch is inferred.
        w_mask = '0;
        w_sel  = 0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
        w_dbl = {i_req, i_req & w_mask};
        // Scan downwards so the lowest set position wins
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (w_dbl[i]) w_sel = i;
        end
        o_gnt_valid = |i_req;
        o_gnt_idx   = (w_sel >= N) ? PTR_W'(w_sel - N) : PTR_W'(w_sel);
    end

endmodule

// File: rtl/cover_toggle_report_sched.sv
// Toggle-coverage hit collector: dedups hits into a sticky pending bitmap and
// serialises them round-robin onto one valid/ready report port, with flush support.
module cover_toggle_report_sched
    import cover_sched_pkg::*;
#(
    parameter int              NUM_GROUPS  = 4,
    parameter int              GROUP_WIDTH = 5,
    parameter longint unsigned COVER_INDEX = 64'd0,
    parameter longint unsigned COVER_TOTAL = 64'd10906
) (
    input  logic                                                   i_clock,
    input  logic                                                   i_reset,
    input  logic                                                   i_enable,
    input  logic [NUM_GROUPS*GROUP_WIDTH-1:0]                      i_valid,
    input  logic                                                   i_rearm,
    input  logic                                                   i_flush_req,
    output logic                                                   o_flush_done,
    output logic                                                   o_out_valid,
    input  logic                                                   i_out_ready,
    output logic [63:0]                                            o_out_index,
    output logic [clog2_width(NUM_GROUPS*GROUP_WIDTH+1)-1:0]       o_pending_cnt
);

    localparam int N     = NUM_GROUPS * GROUP_WIDTH;
    localparam int PW    = clog2_width(N + 1);
    localparam int PTR_W = clog2_width(N);

    // Elaboration-time sanity check on the global index range
    if (COVER_INDEX + 64'(N) > COVER_TOTAL) begin : g_range_check
        $fatal(1, "cover_toggle_report_sched: COVER_INDEX+N exceeds COVER_TOTAL");
    end

    state_t             r_state;
    logic [N-1:0]       r_pending;
    logic [N-1:0]       r_seen;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_out_valid;
    cover_index_t       r_out_index;
    logic [PW-1:0]      r_pending_cnt;
    logic               r_flush_done;

    logic [N-1:0]       w_new;
    logic               w_load;
    logic               w_pick;
    logic [N-1:0]       w_pick_oh;
    logic [N-1:0]       w_pending_nxt;
    logic               w_gnt_valid;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req       (r_pending),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // Next-state terms: fresh hits, output-register load, and the pending update
    always_comb begin
        w_new     = i_valid & ~r_seen & {N{i_enable && (r_state == RUN)}};
        w_load    = !r_out_valid || i_out_ready;
        w_pick    = w_load && w_gnt_valid;
        w_pick_oh = '0;
        if (w_pick) w_pick_oh[w_gnt_idx] = 1'b1;
        // Picker only sees pre-edge pending, so this edge's captures wait a cycle
        w_pending_nxt = (r_pending & ~w_pick_oh) | w_new;
        w_ptr_nxt     = (w_gnt_idx == PTR_W'(N - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end

    // Pending/seen bitmaps, round-robin pointer, output register and popcount
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pending     <= '0;
            r_seen        <= '0;
            r_ptr         <= '0;
            r_out_valid   <= 1'b0;
            r_out_index   <= '0;
            r_pending_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_pending <= w_pending_nxt;
            // Rearm keeps whatever is still pending deduplicated
            r_seen    <= i_rearm ? w_pending_nxt : (r_seen | w_new);
            if (w_pick) r_ptr <= w_ptr_nxt;
            if (w_load) begin
                r_out_valid <= w_gnt_valid;
                if (w_gnt_valid) r_out_index <= COVER_INDEX + cover_index_t'(w_gnt_idx);
            end
            r_pending_cnt <= PW'($countones(w_pending_nxt));
        end
    end

    // Flush sequencer with registered done flag
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= RUN;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_flush_req) r_state <= FLUSH;
                end
                FLUSH: begin
                    if ((r_pending == '0) && w_load) begin
                        r_state      <= DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!i_flush_req) begin
                        r_state      <= RUN;
                        r_flush_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= RUN;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_flush_done  = r_flush_done;
    assign o_out_valid   = r_out_valid;
    assign o_out_index   = r_out_index;
    assign o_pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_cover_toggle_report_sched.sv
// Scoreboard bench: a behavioural model predicts each report, a negedge monitor compares.
module tb_cover_toggle_report_sched;

    localparam int N     = 20;
    localparam int PW    = 5;
    localparam longint unsigned CI = 64'd0;
    localparam int S_RUN = 0, S_FLUSH = 1, S_DONE = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [N-1:0]  valid = '0;
    logic          rearm = 1'b0;
    logic          flush_req = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush_done;
    logic          out_valid;
    logic [63:0]   out_index;
    logic [PW-1:0] pending_cnt;

    always #5 clock = ~clock;

    cover_toggle_report_sched #(
        .NUM_GROUPS  (4),
        .GROUP_WIDTH (5),
        .COVER_INDEX (CI),
        .COVER_TOTAL (64'd10906)
    ) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_enable      (enable),
        .i_valid       (valid),
        .i_rearm       (rearm),
        .i_flush_req   (flush_req),
        .o_flush_done  (flush_done),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_index   (out_index),
        .o_pending_cnt (pending_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit [N-1:0]  m_pend, m_seen;
    int          m_ptr, m_st, m_cnt, cyc;
    bit          m_hold, started;
    logic [63:0] exp_q[$];

    task automatic model_step();
        bit [N-1:0] old_pend;
        bit [N-1:0] nw;
        bit         load;
        bit         found;
        int         j;
        cyc++;
        if (reset) begin
            m_pend = '0; m_seen = '0; m_ptr = 0; m_st = S_RUN;
            m_hold = 0; m_cnt = 0; exp_q.delete();
            started = 1;
            return;
        end
        old_pend = m_pend;
        nw = (m_st == S_RUN && enable) ? (valid & ~m_seen) : '0;
        load = !m_hold || out_ready;
        if (load) begin
            m_hold = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && m_pend[j]) begin
                    found = 1;
                    exp_q.push_back(CI + 64'(j));
                    m_hold = 1;
                    m_pend[j] = 1'b0;
                    m_ptr = (j + 1) % N;
                end
            end
        end
        m_pend = m_pend | nw;
        m_seen = rearm ? m_pend : (m_seen | nw);
        case (m_st)
            S_RUN:   if (flush_req) m_st = S_FLUSH;
            S_FLUSH: if (old_pend == '0 && load) m_st = S_DONE;
            default: if (!flush_req) m_st = S_RUN;
        endcase
        m_cnt = $countones(m_pend);
    endtask

    always @(posedge clock) model_step();

    // ---------------- monitor ----------------
    int acc_log[$];
    int acc_cyc[$];
    int done_rise_cyc = -1;
    bit prev_done = 0;

    always @(negedge clock) begin
        if (started) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                check("out_index", out_index, exp_q[0]);
                if (out_ready && !reset) begin
                    acc_log.push_back(int'(out_index));
                    acc_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end
            check("pending_cnt", pending_cnt, m_cnt);
            check("flush_done", flush_done, m_st == S_DONE);
            if (flush_done && !prev_done) done_rise_cyc = cyc;
            prev_done = flush_done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; valid = '0; rearm = 1'b0;
        flush_req = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0; enable = 1'b1;
        acc_log.delete(); acc_cyc.delete();
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (m_pend == '0 && !m_hold) break;
            tick();
        end
        if (i == max_cyc) check({name, "_timeout"}, 1, 0);
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_pending_cnt", pending_cnt, 0);
        check("rst_flush_done", flush_done, 0);

        // Two hits in group 0 reported back to back
        out_ready = 1'b1;
        valid = N'(5'b00101);
        tick();
        valid = '0;
        check("t1_cnt_after_capture", pending_cnt, 2);
        wait_drain("t1", 20);
        check("t1_len", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("t1_first", acc_log[0], 0);
            check("t1_second", acc_log[1], 2);
            check("t1_back_to_back", acc_cyc[1] - acc_cyc[0], 1);
        end

        // Held hit reported once; rearm allows a second report
        do_reset();
        out_ready = 1'b1;
        valid[3] = 1'b1;
        repeat (10) tick();
        valid = '0;
        wait_drain("t2a", 20);
        check("t2_single_report", acc_log.size(), 1);
        rearm = 1'b1; tick(); rearm = 1'b0;
        valid[3] = 1'b1; tick(); valid = '0;
        wait_drain("t2b", 20);
        check("t2_rearm_report", acc_log.size(), 2);
        if (acc_log.size() == 2) check("t2_rearm_index", acc_log[1], 3);

        // Back-pressure: report held stable while out_ready is low
        do_reset();
        out_ready = 1'b0;
        valid[1] = 1'b1; valid[7] = 1'b1; valid[12] = 1'b1;
        tick();
        valid = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", out_valid, 1);
            check("t3_stall_index", out_index, 1);
            tick();
        end
        out_ready = 1'b1;
        wait_drain("t3", 20);
        check("t3_len", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check("t3_order0", acc_log[0], 1);
            check("t3_order1", acc_log[1], 7);
            check("t3_order2", acc_log[2], 12);
        end

        // All points at once with pointer parked at 8
        do_reset();
        out_ready = 1'b1;
        valid[7] = 1'b1; tick(); valid = '0;
        wait_drain("t4a", 20);
        rearm = 1'b1; tick(); rearm = 1'b0;
        valid = '1; tick(); valid = '0;
        check("t4_cnt_full", pending_cnt, N);
        wait_drain("t4b", 60);
        check("t4_len", acc_log.size(), N + 1);
        if (acc_log.size() == N + 1) begin
            for (int i = 0; i < N; i++) begin
                check("t4_order", acc_log[i + 1], (8 + i) % N);
                if (i > 0) check("t4_rate", acc_cyc[i + 1] - acc_cyc[i], 1);
            end
        end

        // Flush drains pending and ignores hits while flushing
        do_reset();
        out_ready = 1'b0;
        valid = N'(3'b111); tick(); valid = '0;
        flush_req = 1'b1; tick();
        out_ready = 1'b1;
        valid[4] = 1'b1;
        done_rise_cyc = -1;
        for (int i = 0; i < 30 && !flush_done; i++) tick();
        check("t5_done_seen", flush_done, 1);
        repeat (3) tick();
        valid = '0;
        check("t5_len", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check("t5_order0", acc_log[0], 0);
            check("t5_order1", acc_log[1], 1);
            check("t5_order2", acc_log[2], 2);
            check("t5_done_latency", done_rise_cyc - acc_cyc[2], 1);
        end
        flush_req = 1'b0; tick();
        check("t5_done_clears", flush_done, 0);
        wait_drain("t5", 20);
        check("t5_bit4_dropped", acc_log.size(), 3);

        // Reset mid-handshake drops the held report and clears seen
        do_reset();
        out_ready = 1'b0;
        valid[5] = 1'b1; tick(); valid = '0;
        tick(); tick();
        check("t6_held_valid", out_valid, 1);
        check("t6_held_index", out_index, 5);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_cnt", pending_cnt, 0);
        valid[5] = 1'b1; tick(); valid = '0;
        out_ready = 1'b1;
        wait_drain("t6", 20);
        check("t6_len", acc_log.size(), 1);
        if (acc_log.size() == 1) check("t6_rehit_index", acc_log[0], 5);

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            valid     = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom & $urandom) : '0;
            enable    = ($urandom_range(0, 7) != 0);
            rearm     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) flush_req = ~flush_req;
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; valid = '0; rearm = 1'b0; flush_req = 1'b0; out_ready = 1'b1;
        wait_drain("rand", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cover_toggle_report_sched.md
Name: cover_toggle_report_sched

Overview:
- Collects per-cycle toggle-coverage hits from NUM_GROUPS coverage groups, each GROUP_WIDTH bits wide, into a sticky pending bitmap.
- Deduplicates hits: each cover point is reported at most once until rearmed.
- Serialises pending points, round-robin, onto a single valid/ready report port that drives one shared cover-reporting sink.
- Sits between the coverage-group instances and the reporting back end; supports a flush sequence before end-of-test dump.

Parameters:
- NUM_GROUPS, 4, number of coverage groups feeding the block.
- GROUP_WIDTH, 5, hit bits per group.
- COVER_INDEX, 0, global cover index of bit 0 of group 0.
- COVER_TOTAL, 10906, total cover points in the design; used for the range check only.
- Derived, not overridable: N = NUM_GROUPS*GROUP_WIDTH; PW = clog2(N+1).

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- enable  in  1  capture gate; hits are ignored while low.
- valid  in  N  hit vector; bit g*GROUP_WIDTH+b is group g, point b.
- rearm  in  1  one-cycle pulse; clears the seen mask so every point may be reported again.
- flush_req  in  1  level; request to drain all pending hits.
- flush_done  out  1  high while in DONE state.
- out_valid  out  1  report available.
- out_ready  in  1  sink accepts the report.
- out_index  out  64  global cover index = COVER_INDEX + bit position.
- pending_cnt  out  PW  population count of the pending bitmap, registered.

Behaviour:
- Reset (synchronous) clears: pending, seen, rr_ptr, state=RUN, and all outputs (out_valid=0, out_index=0, pending_cnt=0, flush_done=0). A reset asserted mid-handshake drops the held report without delivering it.
- Capture, RUN state only: new = valid & ~seen & {N{enable}}. At the next edge, pending |= new and seen |= new. Hits arriving in FLUSH or DONE state are ignored and do not set seen.
- Rearm pulse: seen <= pending at that edge, so points still pending stay deduplicated. If rearm coincides with a capture, that capture's new bits are also kept in seen.
- Output register, one entry: it loads when empty (out_valid=0) or when the current report is accepted (out_valid&&out_ready).
  - Loading picks the first set pending bit at or after rr_ptr, wrapping modulo N.
  - The picked bit is cleared from pending in the same edge.
  - rr_ptr <= pick+1, wrapping to 0 after N-1.
- Latency: a hit sampled at edge k can appear on out_valid after edge k+1 at the earliest. Sustained throughput is one report per cycle.
- Handshake: while out_valid=1 && out_ready=0, out_index is held stable and no pick occurs. out_valid never drops without acceptance, except on reset.
- Simultaneous events:
  - Bits captured at an edge are not pickable at that same edge; the picker sees the pre-edge pending.
  - A bit being picked and re-hit at the same edge cannot re-enter pending, because it is already in seen.
- pending_cnt reflects pending after each edge. It excludes the report held in the output register.
- FSM:
  - RUN -> FLUSH when flush_req=1.
  - FLUSH -> DONE when pending==0 and the output register is empty or being accepted.
  - DONE -> RUN when flush_req=0.
  - In DONE, flush_done=1.
  - Reset forces RUN.
- Simulation-only range check: COVER_INDEX+N <= COVER_TOTAL. Violation raises a fatal error at time 0.

Decomposition:
- Package cover_sched_pkg holds:
  - state enum {RUN, FLUSH, DONE};
  - the 64-bit cover-index typedef;
  - a clog2-based width function.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Implemented as a double-width masked priority encoder.
- The top level owns pending, seen, rr_ptr, the output register, the FSM and the popcount.

Test Plan:
- Reset, then valid=5'b00101 (group 0 only), one cycle, enable=1, out_ready=1 -> reports index 0 then 2 on consecutive cycles. pending_cnt goes 2 -> 1 -> 0.
- Hold valid[3]=1 for 10 cycles -> exactly one report, index 3. Pulse rearm, then hit bit 3 again -> a second report, index 3.
- out_ready=0 for 5 cycles with bits 1, 7, 12 pending -> out_valid=1 and out_index=1 stay stable for all 5 cycles. After out_ready=1, indices 1, 7, 12 appear in that order.
- All N=20 bits hit in one cycle, with rr_ptr previously advanced to 8 by earlier reports -> order 8..19, then 0..7, at one per cycle. pending_cnt decrements from 19 to 0.
- flush_req raised with 3 pending and new hits on bit 4 during flush -> the 3 pending are drained and bit 4 is not reported. flush_done rises the cycle after the last acceptance and clears after flush_req drops.
- Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, pending_cnt=0. The same point hit again after reset is reported, because seen was cleared.
